// File: rtl/ialu_pkg.sv
// rtl/ialu_pkg.sv - shared integer ALU types: default width, command codes, flag bundle
package ialu_pkg;

    localparam int IALU_XLEN = 32;

    typedef enum logic [3:0] {
        IALU_CMD_ADD     = 4'd0,
        IALU_CMD_SUB     = 4'd1,
        IALU_CMD_SUB_LT  = 4'd2,
        IALU_CMD_SUB_LTU = 4'd3,
        IALU_CMD_SUB_EQ  = 4'd4,
        IALU_CMD_SUB_NE  = 4'd5,
        IALU_CMD_SUB_GE  = 4'd6,
        IALU_CMD_SUB_GEU = 4'd7,
        IALU_CMD_MIN     = 4'd8,
        IALU_CMD_MAX     = 4'd9,
        IALU_CMD_MINU    = 4'd10,
        IALU_CMD_MAXU    = 4'd11
    } ialu_cmd_e;

    typedef struct packed {
        logic z;
        logic s;
        logic o;
        logic c;
    } ialu_flags_t;

endpackage

// File: rtl/ialu_main_adder_if.sv
// rtl/ialu_main_adder_if.sv - operand/command and result bundle between EXU and the main adder
interface ialu_main_adder_if #(
    parameter int XLEN = ialu_pkg::IALU_XLEN
);
    logic            valid_i;
    logic [XLEN-1:0] exu2ialu_main_op1_i;
    logic [XLEN-1:0] exu2ialu_main_op2_i;
    logic [3:0]      exu2ialu_cmd_i;

    logic            valid_o;
    logic [XLEN-1:0] ialu2exu_main_res_o;
    logic            ialu2exu_cmp_res_o;
    logic            main_sum_pos_ovflw;
    logic            main_sum_neg_ovflw;
    logic            flag_z;
    logic            flag_s;
    logic            flag_o;
    logic            flag_c;
    logic            main_ops_diff_sgn;
    logic            main_ops_non_zero;

    modport master (
        output valid_i, exu2ialu_main_op1_i, exu2ialu_main_op2_i, exu2ialu_cmd_i,
        input  valid_o, ialu2exu_main_res_o, ialu2exu_cmp_res_o,
               main_sum_pos_ovflw, main_sum_neg_ovflw,
               flag_z, flag_s, flag_o, flag_c,
               main_ops_diff_sgn, main_ops_non_zero
    );

    modport slave (
        input  valid_i, exu2ialu_main_op1_i, exu2ialu_main_op2_i, exu2ialu_cmd_i,
        output valid_o, ialu2exu_main_res_o, ialu2exu_cmp_res_o,
               main_sum_pos_ovflw, main_sum_neg_ovflw,
               flag_z, flag_s, flag_o, flag_c,
               main_ops_diff_sgn, main_ops_non_zero
    );
endinterface

// File: rtl/ialu_main_adder_core.sv
// rtl/ialu_main_adder_core.sv - combinational add/sub, flags, overflow and compare
// MAIN_ADDER_MINMAX_EN routes codes 8-11 through the subtract path with LT/LTU as compare.
module ialu_main_adder_core
    import ialu_pkg::*;
#(
    parameter int XLEN = IALU_XLEN
) (
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [3:0]      cmd_i,
    output logic [XLEN-1:0] sum_o,
    output ialu_flags_t     flags_o,
    output logic            pos_ovflw_o,
    output logic            neg_ovflw_o,
    output logic            cmp_o,
    output logic            diff_sgn_o,
    output logic            non_zero_o
);

    logic            is_add;
    logic [XLEN:0]   sum_ext;
    logic            a_msb;
    logic            b_msb;
    logic            r_msb;
    logic            lt_s;

    always_comb begin
        is_add = 1'b1;
        case (cmd_i)
            IALU_CMD_SUB, IALU_CMD_SUB_LT, IALU_CMD_SUB_LTU, IALU_CMD_SUB_EQ,
            IALU_CMD_SUB_NE, IALU_CMD_SUB_GE, IALU_CMD_SUB_GEU: is_add = 1'b0;
`ifdef MAIN_ADDER_MINMAX_EN
            IALU_CMD_MIN, IALU_CMD_MAX, IALU_CMD_MINU, IALU_CMD_MAXU: is_add = 1'b0;
`endif
            default: is_add = 1'b1;
        endcase
    end

    // Bit XLEN is carry for ADD and borrow for every subtract command.
    assign sum_ext = is_add ? ({1'b0, op1_i} + {1'b0, op2_i})
                            : ({1'b0, op1_i} - {1'b0, op2_i});

    assign a_msb = op1_i[XLEN-1];
    assign b_msb = op2_i[XLEN-1];
    assign r_msb = sum_ext[XLEN-1];

    always_comb begin
        pos_ovflw_o = 1'b0;
        neg_ovflw_o = 1'b0;
        if (is_add) begin
            pos_ovflw_o = ~a_msb & ~b_msb &  r_msb;
            neg_ovflw_o =  a_msb &  b_msb & ~r_msb;
        end else begin
            pos_ovflw_o = ~a_msb &  b_msb &  r_msb;
            neg_ovflw_o =  a_msb & ~b_msb & ~r_msb;
        end
    end

    assign sum_o     = sum_ext[XLEN-1:0];
    assign flags_o.c = sum_ext[XLEN];
    assign flags_o.z = (sum_ext[XLEN-1:0] == '0);
    assign flags_o.s = r_msb;
    assign flags_o.o = pos_ovflw_o | neg_ovflw_o;
    assign lt_s      = flags_o.s ^ flags_o.o;

    always_comb begin
        cmp_o = 1'b0;
        case (cmd_i)
            IALU_CMD_SUB_LT:  cmp_o = lt_s;
            IALU_CMD_SUB_LTU: cmp_o = flags_o.c;
            IALU_CMD_SUB_EQ:  cmp_o = flags_o.z;
            IALU_CMD_SUB_NE:  cmp_o = ~flags_o.z;
            IALU_CMD_SUB_GE:  cmp_o = ~lt_s;
            IALU_CMD_SUB_GEU: cmp_o = ~flags_o.c;
`ifdef MAIN_ADDER_MINMAX_EN
            IALU_CMD_MIN, IALU_CMD_MAX:   cmp_o = lt_s;
            IALU_CMD_MINU, IALU_CMD_MAXU: cmp_o = flags_o.c;
`endif
            default:          cmp_o = 1'b0;
        endcase
    end

    assign diff_sgn_o = a_msb ^ b_msb;
    assign non_zero_o = (op1_i != '0) && (op2_i != '0);

endmodule

// File: rtl/ialu_main_adder.sv
// rtl/ialu_main_adder.sv - integer ALU main adder with one-cycle registered outputs
// MAIN_ADDER_MINMAX_EN adds MIN/MAX/MINU/MAXU operand selection.
module ialu_main_adder
    import ialu_pkg::*;
#(
    parameter int XLEN = IALU_XLEN
) (
    input  logic               clk,
    input  logic               rst,
    ialu_main_adder_if.slave   bus
);

    logic [XLEN-1:0] core_sum;
    ialu_flags_t     core_flags;
    logic            core_pos;
    logic            core_neg;
    logic            core_cmp;
    logic            core_diff;
    logic            core_nz;
    logic [XLEN-1:0] sel_res;

    logic [XLEN-1:0] res_d,   res_q;
    ialu_flags_t     flags_d, flags_q;
    logic            cmp_d,   cmp_q;
    logic            pos_d,   pos_q;
    logic            neg_d,   neg_q;
    logic            diff_d,  diff_q;
    logic            nz_d,    nz_q;
    logic            valid_d, valid_q;

    ialu_main_adder_core #(.XLEN(XLEN)) u_core (
        .op1_i       (bus.exu2ialu_main_op1_i),
        .op2_i       (bus.exu2ialu_main_op2_i),
        .cmd_i       (bus.exu2ialu_cmd_i),
        .sum_o       (core_sum),
        .flags_o     (core_flags),
        .pos_ovflw_o (core_pos),
        .neg_ovflw_o (core_neg),
        .cmp_o       (core_cmp),
        .diff_sgn_o  (core_diff),
        .non_zero_o  (core_nz)
    );

    // For min/max the core compare is the LT/LTU outcome of op1 - op2.
    always_comb begin
        sel_res = core_sum;
`ifdef MAIN_ADDER_MINMAX_EN
        case (bus.exu2ialu_cmd_i)
            IALU_CMD_MIN, IALU_CMD_MINU:
                sel_res = core_cmp ? bus.exu2ialu_main_op1_i : bus.exu2ialu_main_op2_i;
            IALU_CMD_MAX, IALU_CMD_MAXU:
                sel_res = core_cmp ? bus.exu2ialu_main_op2_i : bus.exu2ialu_main_op1_i;
            default: sel_res = core_sum;
        endcase
`endif
    end

    always_comb begin
        valid_d = bus.valid_i;
        res_d   = res_q;
        flags_d = flags_q;
        cmp_d   = cmp_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        diff_d  = diff_q;
        nz_d    = nz_q;
        if (bus.valid_i) begin
            res_d   = sel_res;
            flags_d = core_flags;
            cmp_d   = core_cmp;
            pos_d   = core_pos;
            neg_d   = core_neg;
            diff_d  = core_diff;
            nz_d    = core_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            cmp_q   <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            diff_q  <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cmp_q   <= cmp_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            diff_q  <= diff_d;
            nz_q    <= nz_d;
        end
    end

    assign bus.valid_o             = valid_q;
    assign bus.ialu2exu_main_res_o = res_q;
    assign bus.ialu2exu_cmp_res_o  = cmp_q;
    assign bus.main_sum_pos_ovflw  = pos_q;
    assign bus.main_sum_neg_ovflw  = neg_q;
    assign bus.flag_z              = flags_q.z;
    assign bus.flag_s              = flags_q.s;
    assign bus.flag_o              = flags_q.o;
    assign bus.flag_c              = flags_q.c;
    assign bus.main_ops_diff_sgn   = diff_q;
    assign bus.main_ops_non_zero   = nz_q;

endmodule

// File: tb/tb_ialu_main_adder.sv
// tb/tb_ialu_main_adder.sv - randomized self-checking bench for ialu_main_adder
module tb_ialu_main_adder;
    import ialu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ialu_main_adder_if #(.XLEN(XLEN)) bus ();

    ialu_main_adder #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected register contents.
    logic [31:0] m_res;
    logic        m_cmp;
    logic [7:0]  m_fl;     // {pos, neg, z, s, o, c, diff_sgn, non_zero}
    logic        m_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic cmp, output logic [7:0] fl);
        longint sa, sb, st;
        logic [31:0] r;
        logic is_sub, mm, lt, ltu, c, pos, neg;
        mm = 1'b0;
`ifdef MAIN_ADDER_MINMAX_EN
        mm = (cmd >= 4'd8) && (cmd <= 4'd11);
`endif
        is_sub = ((cmd >= 4'd1) && (cmd <= 4'd7)) || mm;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        st  = is_sub ? sa - sb : sa + sb;
        r   = is_sub ? a - b : a + b;
        c   = is_sub ? (a < b) : (({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF);
        pos = st > 64'sd2147483647;
        neg = st < -64'sd2147483648;
        lt  = sa < sb;
        ltu = a < b;
        res = r;
        case (cmd)
            4'd2:    cmp = lt;
            4'd3:    cmp = ltu;
            4'd4:    cmp = (a == b);
            4'd5:    cmp = (a != b);
            4'd6:    cmp = !lt;
            4'd7:    cmp = !ltu;
            default: cmp = 1'b0;
        endcase
        if (mm) begin
            cmp = cmd[1] ? ltu : lt;
            if (!cmd[0]) res = cmp ? a : b;
            else         res = cmp ? b : a;
        end
        fl = {pos, neg, (r == 32'd0), r[31], pos | neg, c, a[31] ^ b[31], (a != 0) && (b != 0)};
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_res;
        logic        e_cmp;
        logic [7:0]  e_fl;
        rst                     = r;
        bus.valid_i             = v;
        bus.exu2ialu_cmd_i      = cmd;
        bus.exu2ialu_main_op1_i = a;
        bus.exu2ialu_main_op2_i = b;
        model(cmd, a, b, e_res, e_cmp, e_fl);
        if (r) begin
            m_res = '0; m_cmp = 1'b0; m_fl = '0; m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                m_res = e_res; m_cmp = e_cmp; m_fl = e_fl;
            end
        end
        @(posedge clk);
        #1;
        check("valid_o", 64'(bus.valid_o), 64'(m_valid));
        check("result", 64'(bus.ialu2exu_main_res_o), 64'(m_res));
        check("cmp_res", 64'(bus.ialu2exu_cmp_res_o), 64'(m_cmp));
        check("flags", 64'({bus.main_sum_pos_ovflw, bus.main_sum_neg_ovflw, bus.flag_z, bus.flag_s,
                            bus.flag_o, bus.flag_c, bus.main_ops_diff_sgn, bus.main_ops_non_zero}),
              64'(m_fl));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.exu2ialu_cmd_i = '0;
        bus.exu2ialu_main_op1_i = '0;
        bus.exu2ialu_main_op2_i = '0;

        step(1'b1, 1'b1, IALU_CMD_ADD, 32'h5, 32'h3);
        step(1'b1, 1'b1, IALU_CMD_ADD, 32'h5, 32'h3);
        check("reset_all_zero", 64'({bus.valid_o, bus.ialu2exu_main_res_o, bus.flag_z, bus.flag_c}), 64'd0);

        step(1'b0, 1'b1, IALU_CMD_ADD, 32'h7FFF_FFFF, 32'h1);
        check("add_pos_ovf_res", 64'(bus.ialu2exu_main_res_o), 64'h8000_0000);
        check("add_pos_ovf", 64'({bus.main_sum_pos_ovflw, bus.flag_o, bus.flag_s, bus.flag_c, bus.flag_z}), 64'b11100);

        step(1'b0, 1'b1, IALU_CMD_ADD, 32'hFFFF_FFFF, 32'h1);
        check("add_carry", 64'({bus.flag_c, bus.flag_z, bus.flag_o, bus.main_ops_diff_sgn, bus.main_ops_non_zero}), 64'b11011);

        step(1'b0, 1'b1, IALU_CMD_SUB_EQ, 32'h5, 32'h5);
        check("sub_eq_cmp", 64'(bus.ialu2exu_cmp_res_o), 64'd1);
        step(1'b0, 1'b1, IALU_CMD_SUB_NE, 32'h5, 32'h5);
        check("sub_ne_cmp", 64'(bus.ialu2exu_cmp_res_o), 64'd0);

        step(1'b0, 1'b1, IALU_CMD_SUB_LT, 32'hFFFF_FFFF, 32'h1);
        check("sub_lt", 64'({bus.ialu2exu_main_res_o, bus.ialu2exu_cmp_res_o}), {31'd0, 32'hFFFF_FFFE, 1'b1});
        step(1'b0, 1'b1, IALU_CMD_SUB_LTU, 32'hFFFF_FFFF, 32'h1);
        check("sub_ltu_cmp", 64'(bus.ialu2exu_cmp_res_o), 64'd0);

        step(1'b0, 1'b1, IALU_CMD_SUB_GE, 32'h8000_0000, 32'h1);
        check("sub_ge_neg_ovf", 64'({bus.ialu2exu_main_res_o, bus.main_sum_neg_ovflw, bus.flag_o, bus.ialu2exu_cmp_res_o}),
              {29'd0, 32'h7FFF_FFFF, 3'b110});

        // Data outputs hold across idle cycles.
        step(1'b0, 1'b0, IALU_CMD_ADD, 32'h1234, 32'h1);
        check("hold_res", 64'(bus.ialu2exu_main_res_o), 64'h7FFF_FFFF);

`ifdef MAIN_ADDER_MINMAX_EN
        step(1'b0, 1'b1, IALU_CMD_MIN, 32'hFFFF_FFFF, 32'h1);
        check("min_res", 64'(bus.ialu2exu_main_res_o), 64'hFFFF_FFFF);
        step(1'b0, 1'b1, IALU_CMD_MINU, 32'hFFFF_FFFF, 32'h1);
        check("minu_res", 64'(bus.ialu2exu_main_res_o), 64'h1);
`else
        step(1'b0, 1'b1, IALU_CMD_MIN, 32'hFFFF_FFFF, 32'h1);
        check("code8_as_add", 64'({bus.ialu2exu_main_res_o, bus.ialu2exu_cmp_res_o}), 64'd0);
`endif

        // Reset in flight discards the result presented on the same edge.
        step(1'b1, 1'b1, IALU_CMD_ADD, 32'h10, 32'h20);
        step(1'b0, 1'b1, IALU_CMD_SUB, 32'h10, 32'h20);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
